gpio_ctrl: RTL and testbench

Memory-mapped controller for the bidirectional GPIO pad block. Holds the per-pin direction and output registers that drive the pad tristate control. Brings the pad readback into the clock domain through a 2-flop synchronizer and detects rising and falling edges. Raises a level interrupt from sticky, maskable edge status; it sits between the core's peripheral bus and the pad block.

---
 rtl/gpio_pkg.sv | 26 ++
 rtl/gpio_if.sv | 28 ++
 rtl/gpio_sync_edge.sv | 42 ++++
 rtl/gpio_ctrl.sv | 172 +++++++++++++++++
 tb/tb_gpio_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register word offsets,
// bus FSM state encoding and address decode helper.
package gpio_pkg;

  localparam int ADDR_W = 5;

  localparam logic [2:0] GPIO_DIR     = 3'd0;
  localparam logic [2:0] GPIO_OUT     = 3'd1;
  localparam logic [2:0] GPIO_IN      = 3'd2;
  localparam logic [2:0] GPIO_RISE_IE = 3'd3;
  localparam logic [2:0] GPIO_FALL_IE = 3'd4;
  localparam logic [2:0] GPIO_STATUS  = 3'd5;
  localparam logic [2:0] GPIO_OUT_SET = 3'd6;
  localparam logic [2:0] GPIO_OUT_CLR = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_e;

  // Byte address to word offset; the two low byte-lane bits carry no meaning.
  function automatic logic [2:0] word_index(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/gpio_if.sv
// Request/response bus between the core and the GPIO controller.
interface gpio_if
  import gpio_pkg::*;
#(
  parameter int DATA_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/gpio_sync_edge.sv
// Two-flop synchronizer for asynchronous pad readback, plus a one-cycle
// delayed copy used to detect rising and falling edges on every bit.
module gpio_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q,  prev_d;

  // Next-state for the synchronizer chain and history register.
  always_comb begin
    sync1_d = async_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchronizer and history flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = sync2_q;
  assign rise_o = sync2_q & ~prev_q;
  assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: direction/output registers for the pad
// block, synchronized input readback, sticky maskable edge status and irq.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int NUMGPIO = 8,
  parameter int DATA_W  = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  gpio_if.slave              bus,
  output logic [NUMGPIO-1:0] gpio_dir,
  output logic [NUMGPIO-1:0] gpio_out,
  input  logic [NUMGPIO-1:0] gpio_in,
  output logic               irq
);

  bus_state_e         state_q, state_d;
  logic [NUMGPIO-1:0] dir_q, dir_d;
  logic [NUMGPIO-1:0] out_q, out_d;
  logic [NUMGPIO-1:0] rise_ie_q, rise_ie_d;
  logic [NUMGPIO-1:0] fall_ie_q, fall_ie_d;
  logic [NUMGPIO-1:0] status_q, status_d;
  logic               irq_q, irq_d;
  logic               resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]  resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;

  logic [NUMGPIO-1:0] in_sync_s;
  logic [NUMGPIO-1:0] rise_s;
  logic [NUMGPIO-1:0] fall_s;
  logic [NUMGPIO-1:0] wbits_s;
  logic [NUMGPIO-1:0] w1c_s;
  logic [DATA_W-1:0]  rd_data_s;
  logic               rd_err_s;
  logic [2:0]         widx_s;
  logic               unused_s;

  function automatic logic [DATA_W-1:0] zext(input logic [NUMGPIO-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    r[NUMGPIO-1:0] = v;
    return r;
  endfunction

  gpio_sync_edge #(
    .WIDTH (NUMGPIO)
  ) u_sync_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .async_i (gpio_in),
    .sync_o  (in_sync_s),
    .rise_o  (rise_s),
    .fall_o  (fall_s)
  );

  assign widx_s   = word_index(bus.req_addr);
  assign wbits_s  = bus.req_wdata[NUMGPIO-1:0];
  assign unused_s = ^{bus.req_addr[1:0], bus.req_wdata};

  // Read mux; a hole in the map would land in the default arm.
  always_comb begin
    rd_data_s = '0;
    rd_err_s  = 1'b0;
    case (widx_s)
      GPIO_DIR:     rd_data_s = zext(dir_q);
      GPIO_OUT:     rd_data_s = zext(out_q);
      GPIO_IN:      rd_data_s = zext(in_sync_s);
      GPIO_RISE_IE: rd_data_s = zext(rise_ie_q);
      GPIO_FALL_IE: rd_data_s = zext(fall_ie_q);
      GPIO_STATUS:  rd_data_s = zext(status_q);
      GPIO_OUT_SET: rd_data_s = '0;
      GPIO_OUT_CLR: rd_data_s = '0;
      default: begin
        rd_data_s = '0;
        rd_err_s  = 1'b1;
      end
    endcase
  end

  // Bus FSM, register writes, status update and irq.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    out_d        = out_q;
    rise_ie_d    = rise_ie_q;
    fall_ie_d    = fall_ie_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    w1c_s        = '0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = rd_err_s;
          if (bus.req_write) begin
            resp_rdata_d = '0;
            case (widx_s)
              GPIO_DIR:     dir_d     = wbits_s;
              GPIO_OUT:     out_d     = wbits_s;
              GPIO_RISE_IE: rise_ie_d = wbits_s;
              GPIO_FALL_IE: fall_ie_d = wbits_s;
              GPIO_STATUS:  w1c_s     = wbits_s;
              GPIO_OUT_SET: out_d     = out_q | wbits_s;
              GPIO_OUT_CLR: out_d     = out_q & ~wbits_s;
              default:      w1c_s     = '0;
            endcase
          end else begin
            resp_rdata_d = rd_data_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase

    // A new enabled edge outranks a clear on the same bit.
    status_d = (status_q & ~w1c_s) | (rise_s & rise_ie_q) | (fall_s & fall_ie_q);
    irq_d    = |status_q;
  end

  // Controller state flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dir_q        <= '0;
      out_q        <= '0;
      rise_ie_q    <= '0;
      fall_ie_q    <= '0;
      status_q     <= '0;
      irq_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      out_q        <= out_d;
      rise_ie_q    <= rise_ie_d;
      fall_ie_q    <= fall_ie_d;
      status_q     <= status_d;
      irq_q        <= irq_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign gpio_dir       = dir_q;
  assign gpio_out       = out_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed, table-driven bench for gpio_ctrl with hand-written sequences
// for edge timing, W1C races, backpressure and mid-transaction reset.
module tb_gpio_ctrl;
  import gpio_pkg::*;

  logic       clock;
  logic       reset_n;
  logic [7:0] gpio_dir;
  logic [7:0] gpio_out;
  logic [7:0] gpio_in;
  logic       irq;

  int n_cmp;
  int n_bad;

  gpio_if #(.DATA_W(32)) bus_if ();

  gpio_ctrl #(
    .NUMGPIO (8),
    .DATA_W  (32)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .gpio_dir (gpio_dir),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in),
    .irq      (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_dir;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic txn(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    @(negedge clock);
    check("req_ready_idle", 32'(bus_if.req_ready), 32'h1);
    check("resp_valid_pre", 32'(bus_if.resp_valid), 32'h0);
    bus_if.req_valid = 1'b1;
    bus_if.req_write = wr;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wdata;
    @(posedge clock);
    #1;
    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'b0;
    bus_if.req_wdata = 32'h0;
    check("resp_valid_lat", 32'(bus_if.resp_valid), 32'h1);
    rdata = bus_if.resp_rdata;
    err   = bus_if.resp_err;
    bus_if.resp_ready = 1'b1;
    @(posedge clock);
    #1;
    bus_if.resp_ready = 1'b0;
    check("resp_valid_drop", 32'(bus_if.resp_valid), 32'h0);
  endtask

  task automatic rd_check(input string name, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    txn(1'b0, addr, 32'h0, rd, er);
    check(name, rd, exp);
    check({name, "_err"}, 32'(er), 32'h0);
  endtask

  task automatic wr_only(input logic [4:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    logic        er;
    txn(1'b1, addr, wdata, rd, er);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    n_cmp = 0;
    n_bad = 0;

    vecs[0]  = '{1'b0, 5'h00, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 5'h00, 32'h0000_00F0, 32'h0000_0000, 1'b0, 8'hF0, 8'h00};
    vecs[2]  = '{1'b1, 5'h04, 32'h0000_00A5, 32'h0000_0000, 1'b0, 8'hF0, 8'hA5};
    vecs[3]  = '{1'b1, 5'h18, 32'h0000_0002, 32'h0000_0000, 1'b0, 8'hF0, 8'hA7};
    vecs[4]  = '{1'b1, 5'h1C, 32'h0000_0080, 32'h0000_0000, 1'b0, 8'hF0, 8'h27};
    vecs[5]  = '{1'b0, 5'h04, 32'h0000_0000, 32'h0000_0027, 1'b0, 8'hF0, 8'h27};
    vecs[6]  = '{1'b0, 5'h18, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'hF0, 8'h27};
    vecs[7]  = '{1'b0, 5'h1C, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'hF0, 8'h27};
    vecs[8]  = '{1'b1, 5'h08, 32'h0000_00FF, 32'h0000_0000, 1'b0, 8'hF0, 8'h27};
    vecs[9]  = '{1'b0, 5'h08, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'hF0, 8'h27};
    vecs[10] = '{1'b1, 5'h00, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 8'hFF, 8'h27};
    vecs[11] = '{1'b0, 5'h00, 32'h0000_0000, 32'h0000_00FF, 1'b0, 8'hFF, 8'h27};
    vecs[12] = '{1'b1, 5'h0C, 32'h0000_0101, 32'h0000_0000, 1'b0, 8'hFF, 8'h27};
    vecs[13] = '{1'b0, 5'h0C, 32'h0000_0000, 32'h0000_0001, 1'b0, 8'hFF, 8'h27};
    vecs[14] = '{1'b1, 5'h13, 32'h0000_0080, 32'h0000_0000, 1'b0, 8'hFF, 8'h27};
    vecs[15] = '{1'b0, 5'h10, 32'h0000_0000, 32'h0000_0080, 1'b0, 8'hFF, 8'h27};
    vecs[16] = '{1'b0, 5'h14, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'hFF, 8'h27};
    vecs[17] = '{1'b1, 5'h05, 32'h0000_0033, 32'h0000_0000, 1'b0, 8'hFF, 8'h33};

    reset_n           = 1'b0;
    gpio_in           = 8'h00;
    bus_if.req_valid  = 1'b0;
    bus_if.req_write  = 1'b0;
    bus_if.req_addr   = 5'h00;
    bus_if.req_wdata  = 32'h0;
    bus_if.resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_dir",        32'(gpio_dir), 32'h0);
    check("rst_out",        32'(gpio_out), 32'h0);
    check("rst_irq",        32'(irq), 32'h0);
    check("rst_resp_valid", 32'(bus_if.resp_valid), 32'h0);
    check("rst_resp_rdata", bus_if.resp_rdata, 32'h0);
    check("rst_resp_err",   32'(bus_if.resp_err), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_dir", i), 32'(gpio_dir), 32'(vecs[i].exp_dir));
      check($sformatf("vec%0d_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
    end

    // Rising edge on pin 0 with RISE_IE=0x01: irq rises on the 4th clock.
    @(negedge clock);
    gpio_in = 8'h01;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("edge_irq_clk%0d", k), 32'(irq), (k == 4) ? 32'h1 : 32'h0);
    end
    rd_check("status_after_rise", 5'h14, 32'h0000_0001);

    // Falling edge with FALL_IE[0]=0 must not change STATUS.
    @(negedge clock);
    gpio_in = 8'h00;
    repeat (5) @(posedge clock);
    rd_check("status_after_fall", 5'h14, 32'h0000_0001);
    check("irq_after_fall", 32'(irq), 32'h1);

    // W1C accepted on the very edge a new enabled rise is detected.
    @(negedge clock);
    gpio_in = 8'h01;
    @(posedge clock);
    @(posedge clock);
    wr_only(5'h14, 32'h0000_0001);
    rd_check("status_w1c_race", 5'h14, 32'h0000_0001);
    check("irq_w1c_race", 32'(irq), 32'h1);

    // Plain W1C clears the status and then irq.
    wr_only(5'h14, 32'h0000_0001);
    check("irq_after_w1c", 32'(irq), 32'h0);
    rd_check("status_after_w1c", 5'h14, 32'h0000_0000);

    // Pin 1 rises while its enable is off; enabling afterwards captures nothing.
    @(negedge clock);
    gpio_in = 8'h03;
    repeat (5) @(posedge clock);
    wr_only(5'h0C, 32'h0000_0003);
    rd_check("status_no_retro", 5'h14, 32'h0000_0000);
    wr_only(5'h10, 32'h0000_0001);

    // Backpressure: response held while the pads change underneath.
    @(negedge clock);
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = 5'h08;
    @(posedge clock);
    #1;
    bus_if.req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (k == 0) gpio_in = 8'h00;
      check($sformatf("bp_req_ready%0d", k), 32'(bus_if.req_ready), 32'h0);
      check($sformatf("bp_resp_valid%0d", k), 32'(bus_if.resp_valid), 32'h1);
      check($sformatf("bp_rdata%0d", k), bus_if.resp_rdata, 32'h0000_0003);
    end
    bus_if.resp_ready = 1'b1;
    @(posedge clock);
    #1;
    bus_if.resp_ready = 1'b0;
    check("bp_release_valid", 32'(bus_if.resp_valid), 32'h0);
    check("bp_release_ready", 32'(bus_if.req_ready), 32'h1);
    check("bp_fall_irq", 32'(irq), 32'h1);

    // Asynchronous reset while a response is pending.
    @(negedge clock);
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = 5'h00;
    @(posedge clock);
    #1;
    bus_if.req_valid = 1'b0;
    check("mid_resp_valid", 32'(bus_if.resp_valid), 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_dir",        32'(gpio_dir), 32'h0);
    check("arst_out",        32'(gpio_out), 32'h0);
    check("arst_irq",        32'(irq), 32'h0);
    check("arst_resp_valid", 32'(bus_if.resp_valid), 32'h0);
    check("arst_resp_rdata", bus_if.resp_rdata, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    rd_check("dir_after_reset", 5'h00, 32'h0000_0000);
    rd_check("out_after_reset", 5'h04, 32'h0000_0000);
    rd_check("status_after_reset", 5'h14, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
